// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: captures two WIDTH-bit operands and a carry-in on start, adds
// them LSB-first one bit per clock through a registered carry, then pulses done.
module serial_adder_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic [WIDTH-1:0] s_sh_nxt;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  // Half-adder cell: {carry, sum}.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  // Full-adder step built from two half-adder cells with an OR on the carries.
  logic [1:0] ha_ab;
  logic [1:0] ha_abc;
  logic       bit_sum;
  logic       bit_carry;

  always_comb begin
    ha_ab     = half_add(a_sh[0], b_sh[0]);
    ha_abc    = half_add(ha_ab[0], carry);
    bit_sum   = ha_abc[0];
    bit_carry = ha_ab[1] | ha_abc[1];
  end

  // The sum bit enters at the MSB so that after WIDTH shifts bit 0 holds the LSB.
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign s_sh_nxt = bit_sum;
    end else begin : g_sum_wn
      assign s_sh_nxt = {bit_sum, s_sh[WIDTH-1:1]};
    end
  endgenerate

  // The oldest partial-sum bit is always shifted out, never read.
  logic s_lsb_unused;
  assign s_lsb_unused = s_sh[0];

  logic last_bit;
  logic accept;

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign accept   = start && ((state == IDLE) || (state == DONE));

  // NOTE: every variable written in always_comb gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      s_sh   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (accept) begin
      a_sh  <= a_in;
      b_sh  <= b_in;
      s_sh  <= '0;
      carry <= cin;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      s_sh  <= s_sh_nxt;
      carry <= bit_carry;
      cnt   <= cnt + 1'b1;
      // Result registers only move on the completion edge and hold otherwise.
      if (last_bit) begin
        sum_q  <= s_sh_nxt;
        cout_q <= bit_carry;
      end
    end
  end

  assign busy    = (state == SHIFT);
  assign done    = (state == DONE);
  assign sum_out = sum_q;
  assign cout    = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of serial_adder_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_adder_ctrl;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;

  logic       start = 1'b0;
  logic [7:0] a_in  = '0;
  logic [7:0] b_in  = '0;
  logic       cin   = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] sum_out;
  logic       cout;

  logic       start1 = 1'b0;
  logic       a1     = 1'b0;
  logic       b1     = 1'b0;
  logic       cin1   = 1'b0;
  logic       busy1;
  logic       done1;
  logic       sum1;
  logic       cout1;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
    .busy(busy), .done(done), .sum_out(sum_out), .cout(cout)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a_in(a1), .b_in(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum_out(sum1), .cout(cout1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the following posedge accepts the request.
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic ci);
    a_in  = a;
    b_in  = b;
    cin   = ci;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // n0 = negedges already seen after the accepting edge; returns in the DONE cycle.
  task automatic wait_done(input string tag, input logic [8:0] exp, input int n0);
    int   n       = n0;
    logic busy_ok = 1'b1;
    while (!done && n < 40) begin
      if (!busy) busy_ok = 1'b0;
      n++;
      @(negedge clk);
    end
    check({tag, " latency"}, n, 8);
    check({tag, " busy held"}, busy_ok, 1'b1);
    check({tag, " done"}, done, 1'b1);
    check({tag, " busy in done"}, busy, 1'b0);
    check({tag, " result"}, {cout, sum_out}, exp);
  endtask

  task automatic count_dones(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check(tag, seen, 0);
  endtask

  logic [7:0] vec_a [3] = '{8'hFF, 8'h5A, 8'h00};
  logic [7:0] vec_b [3] = '{8'h01, 8'hA5, 8'h00};
  logic       vec_c [3] = '{1'b0, 1'b1, 1'b0};
  logic [8:0] vec_s [3] = '{9'h100, 9'h100, 9'h000};

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    logic [1:0] e1;

    // Reset state.
    @(negedge clk);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst sum", sum_out, 8'h00);
    check("rst cout", cout, 1'b0);
    check("rst busy1", busy1, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic addition with latency and pulse width.
    launch(8'h3C, 8'h0F, 1'b0);
    wait_done("t1", 9'h04B, 0);
    @(negedge clk);
    check("t1 done width", done, 1'b0);
    check("t1 sum held", sum_out, 8'h4B);

    for (int i = 0; i < 3; i++) begin
      launch(vec_a[i], vec_b[i], vec_c[i]);
      wait_done($sformatf("t2.%0d", i), vec_s[i], 0);
      @(negedge clk);
      check($sformatf("t2.%0d done width", i), done, 1'b0);
    end

    // start held through SHIFT with a_in changing: operands must not be re-captured.
    a_in  = 8'h12;
    b_in  = 8'h34;
    cin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      a_in = 8'hFF;
      @(negedge clk);
    end
    start = 1'b0;
    wait_done("t3", 9'h046, 4);
    count_dones("t3 extra done", 12);

    // Back-to-back: second request lands in the DONE cycle.
    launch(8'h11, 8'h22, 1'b0);
    wait_done("t4a", 9'h033, 0);
    launch(8'h80, 8'h80, 1'b0);
    wait_done("t4b", 9'h100, 0);
    @(negedge clk);
    check("t4 done width", done, 1'b0);

    // Asynchronous reset mid-SHIFT.
    launch(8'h77, 8'h11, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5 busy", busy, 1'b0);
    check("t5 done", done, 1'b0);
    check("t5 sum", sum_out, 8'h00);
    check("t5 cout", cout, 1'b0);
    @(negedge clk);
    #3 rst_n = 1'b1;
    count_dones("t5 stale done", 15);
    launch(8'h01, 8'h01, 1'b0);
    wait_done("t5 after", 9'h002, 0);
    @(negedge clk);

    // Random vectors, WIDTH=8 (chained back-to-back from each DONE cycle).
    for (int i = 0; i < 500; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      launch(ra, rb, rc);
      wait_done("rand8", 9'(ra) + 9'(rb) + 9'(rc), 0);
    end
    @(negedge clk);

    // Random vectors, WIDTH=1: done one edge after acceptance.
    for (int i = 0; i < 500; i++) begin
      a1     = 1'($urandom);
      b1     = 1'($urandom);
      cin1   = 1'($urandom);
      e1     = 2'(a1) + 2'(b1) + 2'(cin1);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      check("rand1 busy", busy1, 1'b1);
      check("rand1 early done", done1, 1'b0);
      @(negedge clk);
      check("rand1 done", done1, 1'b1);
      check("rand1 busy in done", busy1, 1'b0);
      check("rand1 result", {cout1, sum1}, e1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder stage built around the lab's half-adder cell. Each full-adder step uses two half-adder cells plus an OR on the carry.
Accepts two WIDTH-bit operands and a carry-in on a start strobe. Adds LSB-first, one bit per clock, through a registered carry.
Presents the registered sum and carry-out with a one-cycle done pulse. It is the sequential consumer of the combinational adder cells and is the next lab step after the half/full adder.

Parameters:
WIDTH, 8, operand and sum width in bits (legal range 1..32)
CNT_W, $clog2(WIDTH+1), bit-counter width (derived; do not override)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request strobe; sampled on rising clk
a_in  input  WIDTH  operand A; captured when start is accepted
b_in  input  WIDTH  operand B; captured when start is accepted
cin  input  1  carry-in; captured when start is accepted
busy  output  1  high while addition is in progress
done  output  1  one-cycle pulse when result registers update
sum_out  output  WIDTH  registered sum of the last completed addition
cout  output  1  registered carry-out of the last completed addition

Behaviour:
- Reset (rst_n low, asynchronous, any state): state=IDLE; busy=0, done=0, sum_out=0, cout=0; operand shift regs, carry reg and counter cleared. Reset mid-addition discards the operation; no done pulse follows.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: start=1 at an edge loads A_sh<=a_in, B_sh<=b_in, carry<=cin, cnt<=0, S_sh<=0 -> SHIFT. start=0 stays in IDLE.
- SHIFT: busy=1. Each edge computes the current bit:
  - s = A_sh[0]^B_sh[0]^carry
  - carry <= (A_sh[0]&B_sh[0]) | (carry&(A_sh[0]^B_sh[0]))
  - S_sh <= {s, S_sh[WIDTH-1:1]}
  - A_sh and B_sh shift right with zero fill
  - cnt <= cnt+1
- On the edge where cnt==WIDTH-1 (the last bit):
  - sum_out <= final S_sh value including this bit
  - cout <= carry-out of this bit
  - state -> DONE
- DONE: done=1 and busy=0 for exactly one cycle.
  - start=1 at this edge is accepted exactly as in IDLE (back-to-back operation; done does not re-pulse).
  - Otherwise -> IDLE.
- Latency: start accepted at edge k; busy high from edge k to edge k+WIDTH; done high from edge k+WIDTH to edge k+WIDTH+1.
- start while in SHIFT is ignored. Operands are not re-captured and the counter is unaffected.
- a_in, b_in and cin may change freely after acceptance.
- sum_out and cout are held stable from one DONE to the next, including throughout SHIFT. They change only on the completion edge or at reset.
- Arithmetic: {cout,sum_out} == a_in + b_in + cin, computed modulo 2^(WIDTH+1). No overflow flag.
- WIDTH=1: SHIFT lasts one cycle; done asserts one edge after acceptance.
- done and busy are never high in the same cycle.

Test Plan:
- Reset, then WIDTH=8, a=0x3C, b=0x0F, cin=0, start pulse at edge k -> busy high for edges k..k+8; done high only in cycle k+8; sum_out=0x4B, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum_out=0x00, cout=1. Then a=0x5A, b=0xA5, cin=1 -> sum_out=0x00, cout=1. Then a=0x00, b=0x00, cin=0 -> sum_out=0x00, cout=0, with done pulsing each time.
- Start a=0x12, b=0x34; hold start=1 and change a_in to 0xFF during SHIFT -> exactly one done; sum_out=0x46; the extra start requests are ignored.
- Back-to-back: start asserted in the DONE cycle with a=0x80, b=0x80 -> first result appears; second operation begins immediately; second done 8 cycles later with sum_out=0x00, cout=1; busy low only during each DONE cycle.
- Assert rst_n low asynchronously mid-SHIFT (between edges) -> busy, done, sum_out and cout go 0 immediately; no done pulse after release; a new start after release completes correctly (0x01+0x01 -> 0x02).
- Random self-check with 500 vectors at WIDTH=8 and WIDTH=1 -> {cout,sum_out} matches a+b+cin for every done.
